wbs_pwm_multi: RTL and testbench
================================

WBS_PWM_MULTI -- requirements
Module: wbs_pwm_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of PWM outputs (1..WIDTH).
REQ-002 SHALL have parameter WIDTH, default 8, counter/duty/data width in bits.
REQ-003 SHALL have parameter ADDR_W, default 4, word address width; CHANNELS+3 <= 2**ADDR_W.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port wb_cyc_i  in  1  bus cycle valid.
REQ-007 SHALL have port wb_stb_i  in  1  Wishbone B4 pipelined strobe.
REQ-008 SHALL have port wb_we_i  in  1  write enable.
REQ-009 SHALL have port wb_adr_i  in  ADDR_W  word address.
REQ-010 SHALL have port wb_dat_i  in  WIDTH  write data.
REQ-011 SHALL have port wb_dat_o  out  WIDTH  read data, valid with wb_ack_o.
REQ-012 SHALL have port wb_ack_o  out  1  one-cycle acknowledge.
REQ-013 SHALL have port wb_stall_o  out  1  tied 0.
REQ-014 SHALL have port pwm_o  out  CHANNELS  PWM outputs.
REQ-015 SHALL have port period_o  out  1  one-cycle pulse at period wrap.

Function
REQ-016 SHALL accept a request on any cycle with wb_cyc_i&wb_stb_i=1; SHALL assert wb_ack_o exactly once, on the next cycle; back-to-back requests SHALL give back-to-back acks.
REQ-017 SHALL decode: 0 CTRL (bit0 EN), 1 TOP, 2 POL (bits CHANNELS-1:0), 3+i DUTY[i]; other addresses: write ignored, read 0, still acked.
REQ-018 SHALL hold writes to TOP and DUTY[i] in pending registers; CTRL and POL take effect the cycle after the write.
REQ-019 SHALL return pending TOP/DUTY values, CTRL, POL on reads (upper unused bits 0).
REQ-020 SHALL, with EN=1, increment a WIDTH-bit counter each cycle from 0 to active TOP, then wrap to 0.
REQ-021 SHALL, on the wrap cycle (counter==active TOP, EN=1), copy all pending TOP/DUTY into active registers and pulse period_o for that cycle.
REQ-022 SHALL, when a write to TOP/DUTY coincides with a wrap, load the pre-write pending value at that wrap; the new value applies at the following wrap.
REQ-023 SHALL, with EN=0, hold counter at 0, continuously copy pending into active, keep period_o=0, and drive pwm_o[i]=POL[i].
REQ-024 SHALL, with EN=1, drive pwm_o[i] = (active DUTY[i] > counter) XOR POL[i], registered (one cycle after counter value).
REQ-025 SHALL give DUTY=0 -> constant POL[i]; DUTY > TOP -> constant ~POL[i]; period = TOP+1 cycles.
REQ-026 SHALL, with active TOP=0, keep counter at 0 and pulse period_o every cycle.
REQ-027 SHALL, on EN 1->0 write, reset counter to 0 the following cycle; on 0->1, start counting from 0.

Reset
REQ-028 SHALL, while wb_rst_i=0, force: EN=0, POL=0, all DUTY pending/active=0, TOP pending/active=all ones, counter=0, pwm_o=0, period_o=0, wb_ack_o=0, wb_dat_o=0.
REQ-029 SHALL drop any in-flight request on reset (no ack after release); reset release SHALL be synchronised internally to wb_clk_i.

Verification
REQ-030 Reset, write TOP=9, DUTY[0]=3, EN=1 -> pwm_o[0] high 3 of every 10 cycles, period_o every 10 cycles.
REQ-031 Running with DUTY[0]=3, write DUTY[0]=7 mid-period -> old duty until next period_o, then 7/10 high; no runt pulse.
REQ-032 Write DUTY[1]=0 and DUTY[2]=255 with TOP=9 -> pwm_o[1] constant 0, pwm_o[2] constant 1; POL=4'b0110 -> inverted both.
REQ-033 Write DUTY[0]=5 on exact wrap cycle -> takes effect one period later; readback returns 5 immediately.
REQ-034 Two back-to-back reads (CTRL, unmapped addr 15) -> acks on consecutive cycles, data 1 then 0; stall never asserted.
REQ-035 Assert wb_rst_i=0 mid-period with pending read -> outputs 0 asynchronously, no ack after release, TOP reads 255.

Source files
------------

// File: rtl/wbs_pwm_multi.sv
// wbs_pwm_multi: Wishbone B4 pipelined slave driving CHANNELS PWM outputs with a shared period counter.
// TOP/DUTY writes are double-buffered and reach the active registers only at a period wrap or while disabled.
module wbs_pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [WIDTH-1:0]    wb_dat_i,
  output logic [WIDTH-1:0]    wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_o
);
  logic [1:0] rst_q;
  logic rst_n, req, wr, en, wrap;
  logic [CHANNELS-1:0] pol;
  logic [WIDTH-1:0] top_p, top_a, cnt, rd;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_p, duty_a;
  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i)
    if (!wb_rst_i) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  assign req = wb_cyc_i & wb_stb_i;
  assign wr = req & wb_we_i;
  assign wrap = en && cnt == top_a;
  assign period_o = wrap;
  assign wb_stall_o = 1'b0;
  always_comb begin
    rd = '0;
    if (wb_adr_i == ADDR_W'(0)) rd = WIDTH'(en);
    else if (wb_adr_i == ADDR_W'(1)) rd = top_p;
    else if (wb_adr_i == ADDR_W'(2)) rd = WIDTH'(pol);
    for (int i = 0; i < CHANNELS; i++)
      if (wb_adr_i == ADDR_W'(3 + i)) rd = duty_p[i];
  end
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en <= 1'b0;
      pol <= '0;
      top_p <= '1;
      top_a <= '1;
      duty_p <= '0;
      duty_a <= '0;
      cnt <= '0;
      pwm_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rd : '0;
      if (wr && wb_adr_i == ADDR_W'(0)) en <= wb_dat_i[0];
      if (wr && wb_adr_i == ADDR_W'(1)) top_p <= wb_dat_i;
      if (wr && wb_adr_i == ADDR_W'(2)) pol <= wb_dat_i[CHANNELS-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (wr && wb_adr_i == ADDR_W'(3 + i)) duty_p[i] <= wb_dat_i;
      // Loading from the old pending values here means a write landing on the wrap edge waits a full period.
      if (!en || wrap) begin
        top_a <= top_p;
        duty_a <= duty_p;
      end
      cnt <= (!en || wrap) ? '0 : cnt + WIDTH'(1);
      for (int i = 0; i < CHANNELS; i++)
        pwm_o[i] <= en ? ((duty_a[i] > cnt) ^ pol[i]) : pol[i];
    end
endmodule

// File: tb/tb_wbs_pwm_multi.sv
// tb_wbs_pwm_multi: random and directed bus traffic; each PWM period is checked for length and high-time per channel.
module tb_wbs_pwm_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, cyc, stb, we, ack, stall, period;
  logic [3:0] adr, pwm;
  logic [7:0] dat_i, dat_o;

  wbs_pwm_multi dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_stall_o(stall), .pwm_o(pwm), .period_o(period)
  );

  int checks = 0, errors = 0;
  int m_en, m_top, m_pol, m_duty[4];
  int s_top, s_duty[4], o_top, o_duty[4];
  int pulses, len, hi[4], quiet;
  bit pd, p_req, p_we;
  int p_adr, p_dat;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_rd(input int a);
    if (a == 0) return m_en;
    if (a == 1) return m_top;
    if (a == 2) return m_pol;
    if (a >= 3 && a <= 6) return m_duty[a-3];
    return 0;
  endfunction

  task automatic model_reset();
    m_en = 0; m_top = 255; m_pol = 0; m_duty = '{default: 0};
    pulses = 0; len = 0; hi = '{default: 0}; quiet = 0; pd = 0; p_req = 0;
  endtask

  task automatic drv(input bit r, input bit w, input int a, input int d);
    cyc = r; stb = r; we = w; adr = a[3:0]; dat_i = d[7:0];
    p_req = r; p_we = w; p_adr = a; p_dat = d;
  endtask

  task automatic obs();
    int h, l;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    chk("stall", stall, 0);
    chk("ack", ack, p_req);
    if (p_req && !p_we) chk($sformatf("rdata@%0d", p_adr), dat_o, model_rd(p_adr));
    if (p_req && p_we) begin
      if (p_adr == 0) begin m_en = p_dat & 1; pulses = 0; quiet = 0; end
      else if (p_adr == 1) m_top = p_dat;
      else if (p_adr == 2) begin m_pol = p_dat & 15; quiet = 0; end
      else if (p_adr >= 3 && p_adr <= 6) m_duty[p_adr-3] = p_dat;
    end
    p_req = 0;
    quiet++;
    if (m_en == 0) begin
      chk("period_off", period, 0);
      if (quiet >= 2) chk("pwm_off", pwm, m_pol);
    end
    len++;
    for (int i = 0; i < 4; i++) hi[i] += pwm[i];
    if (pd) begin
      if (pulses >= 2) begin
        l = o_top + 1;
        chk("period_len", len, l);
        for (int i = 0; i < 4; i++) begin
          h = o_duty[i] < l ? o_duty[i] : l;
          chk($sformatf("pwm%0d_high", i), hi[i], ((m_pol >> i) & 1) ? l - h : h);
        end
      end
      len = 0; hi = '{default: 0};
    end
    if (period) begin
      pulses++;
      o_top = s_top; o_duty = s_duty;
      s_top = m_top; s_duty = m_duty;
    end
    pd = period;
  endtask

  task automatic tick(input bit r, input bit w, input int a, input int d);
    drv(r, w, a, d);
    obs();
  endtask

  task automatic run(input int n);
    repeat (n) obs();
  endtask

  initial begin
    rst_n = 0; cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0;
    model_reset();
    run(3);
    chk("rst_dat", dat_o, 0);
    chk("rst_pwm", pwm, 0);
    rst_n = 1;
    run(3);
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 0);
    // 3 of 10 cycles high, then a mid-period change to 7
    tick(1, 1, 1, 9);
    tick(1, 1, 3, 3);
    tick(1, 1, 0, 1);
    run(45);
    run(4);
    tick(1, 1, 3, 7);
    run(35);
    // duty extremes, then inverted polarity
    tick(1, 1, 0, 0);
    tick(1, 1, 4, 0);
    tick(1, 1, 5, 255);
    tick(1, 1, 0, 1);
    run(35);
    tick(1, 1, 0, 0);
    tick(1, 1, 2, 6);
    run(3);
    tick(1, 1, 0, 1);
    run(35);
    // duty write landing exactly on the wrap edge
    begin
      int k = 0;
      while (!pd && k < 50) begin obs(); k++; end
      if (!pd) chk("wrap_timeout", 0, 1);
    end
    tick(1, 1, 3, 5);
    tick(1, 0, 3, 0);
    run(35);
    tick(1, 0, 0, 0);
    tick(1, 0, 15, 0);
    run(2);
    // randomized sessions
    repeat (6) begin
      tick(1, 1, 0, 0);
      tick(1, 1, 2, $urandom_range(0, 15));
      tick(1, 1, 1, $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        tick(1, 1, 3 + i, $urandom_range(0, 4) == 0 ? 255 : $urandom_range(0, 18));
      tick(1, 1, 0, 1);
      repeat (150) begin
        int r = $urandom_range(0, 99);
        if (r < 10) drv(1, 1, $urandom_range(3, 6), $urandom_range(0, 4) == 0 ? 255 : $urandom_range(0, 18));
        else if (r < 14) drv(1, 1, 1, $urandom_range(0, 15));
        else if (r < 17) drv(1, 1, $urandom_range(7, 15), $urandom_range(0, 255));
        else if (r < 32) drv(1, 0, $urandom_range(0, 15), 0);
        obs();
      end
    end
    // reset in the middle of a period with a read outstanding
    drv(1, 0, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_pwm", pwm, 0);
    chk("arst_period", period, 0);
    chk("arst_ack", ack, 0);
    chk("arst_dat", dat_o, 0);
    model_reset();
    run(2);
    rst_n = 1;
    run(4);
    tick(1, 0, 1, 0);
    run(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
